// File: rtl/interp_feed_ctrl.sv
// interp_feed_ctrl: paced sample FIFO feeding the interpolator, one sample per RATE clocks.
// Build option FEED_ZERO_ON_UNDERRUN_EN: when defined, v_out is forced to zero on underrun
// and when dropping to IDLE; when undefined, v_out holds the last sample through both.
module interp_feed_ctrl #(
    parameter int DEPTH     = 8,
    parameter int RATE      = 8,
    parameter int PRIME_LVL = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic                   s_valid_i,
    input  logic [14:0]            s_data_i,
    output logic                   s_ready_o,
    output logic [14:0]            v_out_o,
    output logic                   sample_tick_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [7:0]             underrun_cnt_o,
    output logic [1:0]             state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(RATE);

    typedef enum logic [1:0] {IDLE = 2'b00, PRIME = 2'b01, RUN = 2'b10} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic [14:0]   mem_q [DEPTH];
    logic [14:0]   v_out_q, v_out_d;
    logic          stick_q;
    logic [7:0]    urun_q, urun_d;
    logic          tick, push, pop, underrun;

    assign tick           = phase_q == PW'(RATE - 1);
    assign s_ready_o      = enable_i && state_q != IDLE && level_q != LW'(DEPTH);
    assign push           = s_valid_i && s_ready_o;
    assign v_out_o        = v_out_q;
    assign sample_tick_o  = stick_q;
    assign level_o        = level_q;
    assign underrun_cnt_o = urun_q;
    assign state_o        = state_q;

    // Next state, pop/underrun decision on the prescale tick, FIFO bookkeeping and next output sample.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        underrun = 1'b0;
        case (state_q)
            IDLE:    state_d = enable_i ? PRIME : IDLE;
            PRIME: begin
                if (tick && level_q >= LW'(PRIME_LVL)) begin
                    state_d = RUN;
                    pop     = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    pop      = level_q != '0;
                    underrun = level_q == '0;
                    state_d  = underrun ? PRIME : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable_i) begin
            state_d  = IDLE;
            pop      = 1'b0;
            underrun = 1'b0;
        end
        wr_d    = enable_i ? wr_q + AW'(push) : '0;
        rd_d    = enable_i ? rd_q + AW'(pop) : '0;
        level_d = enable_i ? level_q + LW'(push) - LW'(pop) : '0;
        urun_d  = (underrun && urun_q != 8'hff) ? urun_q + 8'd1 : urun_q;
        v_out_d = pop ? mem_q[rd_q] : v_out_q;
`ifdef FEED_ZERO_ON_UNDERRUN_EN
        if (underrun || !enable_i) v_out_d = '0;
`endif
    end

    // Free-running prescale phase, FSM, FIFO pointers/occupancy and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= '0;
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            v_out_q <= '0;
            stick_q <= 1'b0;
            urun_q  <= '0;
        end else begin
            phase_q <= tick ? '0 : phase_q + PW'(1);
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            v_out_q <= v_out_d;
            stick_q <= pop;
            urun_q  <= urun_d;
        end
    end

    // FIFO storage, written on each accepted push; contents are don't-care while empty.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= s_data_i;
    end
endmodule
